// File: rtl/pipe_dff.sv
// pipe_dff: parametrised WIDTH x DEPTH register pipeline with a valid flag
// per stage. Acts as the standard retiming/delay element.
//
// Parameters:
//   WIDTH   - data bits per stage (>=1)
//   DEPTH   - number of stages (>=1); latency in enabled cycles
//   RST_VAL - value loaded into every stage on reset or flush
//   SET_VAL - value loaded into every stage on preset
//
// Ports:
//   C   in   clock, rising edge
//   R   in   asynchronous active-low reset
//   EN  in   advance enable; 0 holds every stage (stall)
//   CLR in   synchronous flush (highest synchronous priority)
//   S   in   synchronous preset
//   D   in   data into stage 0
//   DV  in   valid flag accompanying D
//   Q   out  data of the last stage
//   QV  out  valid flag of the last stage
//   CNT out  number of stages currently holding valid data
//
// Valid semantics: DV qualifies D and travels with it. There is no
// back-pressure: when EN=1 the last stage is overwritten whether or not
// it was valid, and when EN=0 both D and DV are ignored.
module pipe_dff #(
    parameter int               WIDTH   = 8,
    parameter int               DEPTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0,
    parameter logic [WIDTH-1:0] SET_VAL = '1
) (
    input  logic                         C,
    input  logic                         R,
    input  logic                         EN,
    input  logic                         CLR,
    input  logic                         S,
    input  logic [WIDTH-1:0]             D,
    input  logic                         DV,
    output logic [WIDTH-1:0]             Q,
    output logic                         QV,
    output logic [$clog2(DEPTH+1)-1:0]   CNT
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q [DEPTH];
    logic [DEPTH-1:0] v_q;
    logic [CW-1:0]    cnt_sum;

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            v_q <= '0;
        end else if (CLR) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= RST_VAL;
            end
            v_q <= '0;
        end else if (S) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_q[i] <= SET_VAL;
            end
            v_q <= '1;
        end else if (EN) begin
            // Data shifts regardless of valid so bubbles carry whatever D held.
            data_q[0] <= D;
            v_q[0]    <= DV;
            for (int i = 1; i < DEPTH; i++) begin
                data_q[i] <= data_q[i-1];
                v_q[i]    <= v_q[i-1];
            end
        end
    end

    // Population count of the registered valid flags only, so CNT never
    // depends on the current cycle's inputs.
    always_comb begin
        cnt_sum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            cnt_sum = cnt_sum + CW'(v_q[i]);
        end
    end

    assign Q   = data_q[DEPTH-1];
    assign QV  = v_q[DEPTH-1];
    assign CNT = cnt_sum;

endmodule

// File: tb/tb_pipe_dff.sv
// tb_pipe_dff: directed test of pipe_dff with two instances, the default
// 8-bit x 3-stage pipeline and a 1-bit x 1-stage register.
module tb_pipe_dff;

    logic       clk;
    // 8x3 instance
    logic       r, en, clr, s, dv;
    logic [7:0] d;
    logic [7:0] q;
    logic       qv;
    logic [1:0] cnt;
    // 1x1 instance
    logic       r1, en1, clr1, s1, dv1;
    logic [0:0] d1;
    logic [0:0] q1;
    logic       qv1;
    logic [0:0] cnt1;

    int checks = 0;
    int errors = 0;

    pipe_dff #(.WIDTH(8), .DEPTH(3)) u_dut (
        .C(clk), .R(r), .EN(en), .CLR(clr), .S(s), .D(d), .DV(dv),
        .Q(q), .QV(qv), .CNT(cnt)
    );

    pipe_dff #(.WIDTH(1), .DEPTH(1)) u_dut1 (
        .C(clk), .R(r1), .EN(en1), .CLR(clr1), .S(s1), .D(d1), .DV(dv1),
        .Q(q1), .QV(qv1), .CNT(cnt1)
    );

    // clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic exp3(input string tag, input logic [7:0] eq, input logic eqv, input logic [1:0] ecnt);
        chk({tag, ".Q"},   q,            eq);
        chk({tag, ".QV"},  {7'd0, qv},   {7'd0, eqv});
        chk({tag, ".CNT"}, {6'd0, cnt},  {6'd0, ecnt});
    endtask

    task automatic exp1(input string tag, input logic eq, input logic eqv, input logic ecnt);
        chk({tag, ".Q"},   {7'd0, q1},   {7'd0, eq});
        chk({tag, ".QV"},  {7'd0, qv1},  {7'd0, eqv});
        chk({tag, ".CNT"}, {7'd0, cnt1}, {7'd0, ecnt});
    endtask

    // Advance one rising edge; inputs are applied and outputs sampled 1ns later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] dd, input logic vv);
        en = 1'b1; clr = 1'b0; s = 1'b0; d = dd; dv = vv;
        step();
    endtask

    task automatic flush3();
        clr = 1'b1;
        step();
        clr = 1'b0;
    endtask

    initial begin
        // reset with busy inputs and a running clock
        r = 1'b0; en = 1'b1; clr = 1'b0; s = 1'b0; d = 8'hA5; dv = 1'b1;
        r1 = 1'b0; en1 = 1'b1; clr1 = 1'b0; s1 = 1'b0; d1 = 1'b1; dv1 = 1'b1;
        #2;
        exp3("rst_t0", 8'h00, 1'b0, 2'd0);
        exp1("rst1_t0", 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            exp3("rst_hold", 8'h00, 1'b0, 2'd0);
        end
        exp1("rst1_hold", 1'b0, 1'b0, 1'b0);

        // release reset away from the edge; first sample loads stage 0 only
        r = 1'b1;
        push(8'hA5, 1'b1); exp3("first_e1", 8'h00, 1'b0, 2'd1);
        push(8'h00, 1'b0); exp3("first_e2", 8'h00, 1'b0, 2'd1);
        push(8'h00, 1'b0); exp3("first_e3", 8'hA5, 1'b1, 2'd1);
        flush3();          exp3("flush_a", 8'h00, 1'b0, 2'd0);

        // streaming
        push(8'd1, 1'b1); exp3("str_e1", 8'h00, 1'b0, 2'd1);
        push(8'd2, 1'b1); exp3("str_e2", 8'h00, 1'b0, 2'd2);
        push(8'd3, 1'b1); exp3("str_e3", 8'd1, 1'b1, 2'd3);
        push(8'd4, 1'b1); exp3("str_e4", 8'd2, 1'b1, 2'd3);
        push(8'd5, 1'b1); exp3("str_e5", 8'd3, 1'b1, 2'd3);
        push(8'd6, 1'b1); exp3("str_e6", 8'd4, 1'b1, 2'd3);

        // stall with junk on D
        flush3();
        push(8'h11, 1'b1);
        push(8'h22, 1'b1); exp3("stall_pre", 8'h00, 1'b0, 2'd2);
        en = 1'b0;
        for (int i = 0; i < 4; i++) begin
            d = 8'hE0 + 8'(i); dv = 1'b1;
            step();
            exp3("stall_hold", 8'h00, 1'b0, 2'd2);
        end
        push(8'h33, 1'b1); exp3("stall_res1", 8'h11, 1'b1, 2'd3);
        push(8'h44, 1'b0); exp3("stall_res2", 8'h22, 1'b1, 2'd2);
        push(8'h55, 1'b0); exp3("stall_res3", 8'h33, 1'b1, 2'd1);

        // bubbles
        flush3();
        push(8'hAA, 1'b1);
        push(8'hBB, 1'b0);
        push(8'hCC, 1'b1); exp3("bub_1", 8'hAA, 1'b1, 2'd2);
        push(8'h00, 1'b0); exp3("bub_2", 8'hBB, 1'b0, 2'd1);
        push(8'h00, 1'b0); exp3("bub_3", 8'hCC, 1'b1, 2'd1);

        // flush/preset priority
        push(8'd7, 1'b1);
        push(8'd8, 1'b1);
        push(8'd9, 1'b1); exp3("full", 8'd7, 1'b1, 2'd3);
        clr = 1'b1; s = 1'b1; en = 1'b1; d = 8'h5A; dv = 1'b1;
        step();            exp3("clr_s", 8'h00, 1'b0, 2'd0);
        clr = 1'b0; s = 1'b1; en = 1'b0;
        step();            exp3("preset", 8'hFF, 1'b1, 2'd3);
        s = 1'b0; clr = 1'b1; en = 1'b0;
        step();            exp3("clr_noen", 8'h00, 1'b0, 2'd0);
        clr = 1'b0;

        // async reset mid-stream
        push(8'd1, 1'b1);
        push(8'd2, 1'b1);
        push(8'd3, 1'b1); exp3("pre_ar", 8'd1, 1'b1, 2'd3);
        en = 1'b0;
        #4 r = 1'b0;
        #1;                exp3("ar_now", 8'h00, 1'b0, 2'd0);
        step();            exp3("ar_edge", 8'h00, 1'b0, 2'd0);
        r = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push(8'h00, 1'b0);
            exp3("ar_after", 8'h00, 1'b0, 2'd0);
        end

        // DEPTH=1, WIDTH=1 instance
        r1 = 1'b1; en1 = 1'b1; d1 = 1'b1; dv1 = 1'b1;
        step();            exp1("d1_load", 1'b1, 1'b1, 1'b1);
        en1 = 1'b0; d1 = 1'b0; dv1 = 1'b0;
        step();            exp1("d1_stall", 1'b1, 1'b1, 1'b1);
        #4 r1 = 1'b0;
        #1;                exp1("d1_ar_now", 1'b0, 1'b0, 1'b0);
        step();
        r1 = 1'b1; en1 = 1'b1;
        step();            exp1("d1_ar_after", 1'b0, 1'b0, 1'b0);
        s1 = 1'b1; en1 = 1'b0;
        step();            exp1("d1_preset", 1'b1, 1'b1, 1'b1);
        clr1 = 1'b1;
        step();            exp1("d1_clr_s", 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
